// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its sub-blocks.
package dmem_arb_pkg;

  localparam int unsigned NumCoresDef = 4;
  localparam int unsigned DataWDef    = 16;
  localparam int unsigned AddrWDef    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } arb_state_e;

  // Width of a core index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request bundle plus the shared DRAM port seen by the arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned ADDR_W    = AddrWDef
);

  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        ack;
  logic [DATA_W-1:0]           rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_we;
  logic [DATA_W-1:0]           mem_rdata;

  // Environment side: cores and the DRAM.
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, ack, rdata, mem_addr, mem_wdata, mem_we
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, ack, rdata, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the pointer, wrapping.
module rr_picker #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]     i_rr_ptr,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_idx
);

  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    o_valid  = 1'b0;
    o_idx    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = 32'(i_rr_ptr) + i;
      if (cand >= NUM_CORES) begin
        cand = cand - NUM_CORES;
      end
      cand_idx = IDX_W'(cand);
      if (!o_valid && i_req[cand_idx]) begin
        o_valid = 1'b1;
        o_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising core accesses onto one registered-read DRAM port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned ADDR_W    = AddrWDef
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NUM_CORES);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [IdxW-1:0]      r_idx;
  logic [IdxW-1:0]      r_rr_ptr;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic                 w_pick_valid;
  logic [IdxW-1:0]      w_pick_idx;
  logic [NUM_CORES-1:0] w_onehot;

  rr_picker #(
    .NUM_CORES(NUM_CORES),
    .IDX_W    (IdxW)
  ) u_rr_picker (
    .i_req   (bus.req),
    .i_rr_ptr(r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_onehot    = NUM_CORES'(1) << r_idx;
    bus.gnt     = '0;
    bus.ack     = '0;
    bus.mem_we  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_state_nxt = StAccess;
        end
      end
      StAccess: begin
        bus.gnt     = w_onehot;
        bus.mem_we  = r_we;
        w_state_nxt = StResp;
      end
      StResp: begin
        bus.gnt     = w_onehot;
        bus.ack     = w_onehot;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Address/data come straight from the capture registers so they clear with reset.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (w_pick_valid) begin
            r_idx   <= w_pick_idx;
            r_we    <= bus.we[w_pick_idx];
            r_addr  <= bus.addr[w_pick_idx*ADDR_W +: ADDR_W];
            r_wdata <= bus.wdata[w_pick_idx*DATA_W +: DATA_W];
          end
        end
        StAccess: begin
          if (!r_we) begin
            r_rdata <= bus.mem_rdata;
          end
        end
        StResp: begin
          r_rr_ptr <= (r_idx == IdxW'(NUM_CORES - 1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed core requests, monitor checks acks and DRAM writes.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  typedef struct {
    int          idx;
    bit          rd;
    logic [15:0] data;
    int          gap;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // DRAM model: write on the clock edge, read data follows the address.
  logic [15:0] mem [256];
  bit preset_done = 1'b0;
  always @(posedge clk) begin
    if (!preset_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 16'h1234;
      mem[8'h20] <= 16'hA000;
      mem[8'h21] <= 16'hA001;
      mem[8'h22] <= 16'hA002;
      mem[8'h23] <= 16'hA003;
      mem[8'h30] <= 16'h5A5A;
      preset_done <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_ack = 0;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT acks or strobes a write.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (rst_n) begin
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          chk("mem_we_unexpected", 32'(bus.mem_we), 32'd0);
        end else begin
          w = wr_q.pop_front();
          chk("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
          chk("mem_wdata", 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      if (|bus.ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'(bus.ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_idx", 32'(bus.ack), 32'd1 << e.idx);
          chk("ack_gnt", 32'(bus.gnt), 32'd1 << e.idx);
          if (e.rd) chk("rdata", 32'(bus.rdata), 32'(e.data));
          if (e.gap != 0) chk("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
        end
        last_ack = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input bit r, input bit w, input logic [15:0] a,
                          input logic [15:0] d);
    bus.req[c]           = r;
    bus.we[c]            = w;
    bus.addr[c*16 +: 16]  = a;
    bus.wdata[c*16 +: 16] = d;
  endtask

  task automatic wait_ack(input int c, input int bound);
    int n;
    tick();
    n = 1;
    while (!bus.ack[c] && n < bound) begin
      tick();
      n++;
    end
    chk($sformatf("ack%0d_seen", c), 32'(bus.ack[c]), 32'd1);
  endtask

  task automatic wait_any_ack(input int bound);
    int n;
    tick();
    n = 1;
    while (!(|bus.ack) && n < bound) begin
      tick();
      n++;
    end
    chk("any_ack_seen", 32'(|bus.ack), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_mem_we", 32'(bus.mem_we), 32'd0);

    // Single read by core 2.
    exp_q.push_back('{idx: 2, rd: 1'b1, data: 16'h1234, gap: 0});
    set_core(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    chk("rd_gnt_c1", 32'(bus.gnt), 32'h4);
    chk("rd_mem_addr_c1", 32'(bus.mem_addr), 32'h10);
    chk("rd_mem_we_c1", 32'(bus.mem_we), 32'd0);
    chk("rd_ack_c1", 32'(bus.ack), 32'd0);
    tick();
    chk("rd_gnt_c2", 32'(bus.gnt), 32'h4);
    chk("rd_ack_c2", 32'(bus.ack), 32'h4);
    chk("rd_rdata_c2", 32'(bus.rdata), 32'h1234);
    set_core(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk("rd_idle_gnt", 32'(bus.gnt), 32'd0);

    // Single write by core 1, then read back by core 0.
    exp_q.push_back('{idx: 1, rd: 1'b0, data: 16'h0000, gap: 0});
    wr_q.push_back('{addr: 16'h0005, data: 16'hBEEF});
    set_core(1, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
    tick();
    chk("wr_mem_we_c1", 32'(bus.mem_we), 32'd1);
    wait_ack(1, 4);
    chk("wr_mem_we_resp", 32'(bus.mem_we), 32'd0);
    set_core(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    exp_q.push_back('{idx: 0, rd: 1'b1, data: 16'hBEEF, gap: 0});
    set_core(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    wait_ack(0, 4);
    set_core(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Fairness: all cores requesting out of reset.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 16'(16'h20 + i), 16'h0000);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back('{idx: k % 4, rd: 1'b1, data: 16'(16'hA000 + (k % 4)),
                        gap: (k == 0) ? 0 : 3});
    end
    tick();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) wait_any_ack(5);
    bus.req = '0;
    tick();
    tick();

    // Core 3 drops req during ACCESS; transaction still completes.
    exp_q.push_back('{idx: 3, rd: 1'b1, data: 16'h5A5A, gap: 0});
    set_core(3, 1'b1, 1'b0, 16'h0030, 16'h0000);
    tick();
    chk("drop_gnt_access", 32'(bus.gnt), 32'h8);
    set_core(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_ack(3, 4);
    tick();
    tick();
    chk("drop_idle_gnt", 32'(bus.gnt), 32'd0);

    // Reset during the ACCESS cycle of a write.
    set_core(2, 1'b1, 1'b1, 16'h0040, 16'hCAFE);
    tick();
    chk("rstmid_mem_we_pre", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rstmid_gnt", 32'(bus.gnt), 32'd0);
    chk("rstmid_ack", 32'(bus.ack), 32'd0);
    chk("rstmid_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rstmid_rdata", 32'(bus.rdata), 32'd0);
    set_core(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("rstmid_no_write", 32'(mem[8'h40]), 32'd0);

    // Pointer restarts at 0: core 1 beats core 3, then core 3 follows.
    exp_q.push_back('{idx: 1, rd: 1'b1, data: 16'h1234, gap: 0});
    exp_q.push_back('{idx: 3, rd: 1'b1, data: 16'hBEEF, gap: 3});
    set_core(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_core(3, 1'b1, 1'b0, 16'h0005, 16'h0000);
    wait_ack(1, 4);
    set_core(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_ack(3, 5);
    set_core(3, 1'b0, 1'b0, 16'h0000, 16'h0000);

    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory (16-bit DRAM, registered read) between NUM_CORES processor cores.
- Sits between the per-core data-memory request ports and the shared DRAM instance in the multi-core top level.
- Serialises accesses one at a time with a req/ack handshake per core.
- Rotating priority guarantees no core waits more than NUM_CORES-1 transactions.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
DATA_W, 16, data word width
ADDR_W, 16, data-memory address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_CORES  per-core access request, level, held until ack
we  in  NUM_CORES  per-core write enable (1=write, 0=read), valid with req
addr  in  NUM_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
gnt  out  NUM_CORES  one-hot, core currently owning memory
ack  out  NUM_CORES  one-cycle pulse to the served core, transaction complete
rdata  out  DATA_W  read data broadcast to all cores, valid when ack pulses on a read
mem_addr  out  ADDR_W  address to DRAM
mem_wdata  out  DATA_W  write data to DRAM
mem_we  out  1  DRAM write strobe
mem_rdata  in  DATA_W  DRAM read data, valid one cycle after address presented

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, gnt=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0. Outputs are forced 0 immediately, not at the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first asserted req scanning from rr_ptr upward, mod NUM_CORES.
  - Capture the winning index, we, addr and wdata into registers, then go to ACCESS.
- ACCESS (1 cycle):
  - gnt[idx]=1; mem_addr/mem_wdata driven from the captured registers; mem_we=captured we.
  - Always go to RESP.
- RESP (1 cycle):
  - gnt[idx] stays 1; ack[idx]=1; mem_we=0.
  - On a read, rdata<=mem_rdata, visible in the same cycle ack is high; rdata is registered at the ACCESS->RESP edge.
  - On a write, rdata keeps its previous value.
  - rr_ptr<=(idx+1) mod NUM_CORES; go to IDLE.
- Latency: req seen in IDLE at edge N -> ACCESS cycle N+1 -> ack high in cycle N+2. Minimum 3 cycles per transaction; peak throughput is 1 access per 3 cycles.
- Handshake rules:
  - A core must hold req, we, addr and wdata stable until it sees ack. Values are captured in IDLE, so later changes are ignored.
  - If req drops after capture, the transaction still completes and ack still pulses.
  - If req stays high after ack, that is a new request. It is arbitrated in the next IDLE cycle at rotated priority.
- Simultaneous requests: exactly one winner per arbitration. Losers hold req; no ack is given to them.
- Single requester: served back-to-back every 3 cycles regardless of rr_ptr.
- rr_ptr wraps NUM_CORES-1 -> 0.
- gnt and ack are always one-hot or zero; mem_we is never high outside ACCESS.
- Reset mid-transaction: the transaction is abandoned with no ack and no further mem_we. The core must re-request after reset.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the default widths;
  - the index width function clog2(NUM_CORES).
- One sub-module rr_picker: combinational, inputs req and rr_ptr; outputs valid and winning index. Reusable for a future IM arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> gnt, ack, mem_we, rdata and mem_addr all 0 immediately; after release with req=0, the arbiter stays idle.
- Single read: core 2 req=1, we=0, addr=0x0010, DRAM model holds 0x1234 at 0x0010 -> mem_addr=0x0010 in cycle 1; ack[2]=1 with rdata=0x1234 in cycle 2; gnt=4'b0100 in cycles 1-2.
- Single write: core 1 req=1, we=1, addr=0x0005, wdata=0xBEEF -> mem_we=1 for exactly one cycle with mem_addr=0x0005 and mem_wdata=0xBEEF; ack[1] next cycle; a following read from core 0 at 0x0005 returns 0xBEEF.
- Fairness: all four cores hold req continuously from reset -> ack order 0,1,2,3,0,1, one ack every 3 cycles, no core served twice before the others.
- Req dropped after capture: core 3 requests and deasserts req in the ACCESS cycle -> ack[3] still pulses, then the arbiter returns to idle.
- Reset mid-transaction: rst_n=0 during ACCESS of a write -> mem_we drops immediately, no ack is issued, and rr_ptr=0 after release.
